fpga_top: RTL and testbench
===========================

# fpga_top

Board-level top of the SoC-FPGA video-controller design. Takes the 50 MHz board clock, KEY push-buttons and SW slide switches, derives a clean internal reset, and drives the 8 user LEDs with a heartbeat, a button indicator, a heartbeat-phase counter and the switch state. It also carries the `hws_if` hardware-support interface port used by the surrounding SoC.

## Interface
Parameters:
- `HALF_PERIOD`, default 25_000_000: clock cycles per LED[0] half-period, giving 1 Hz at 50 MHz. When compiled with macro `SIMULATION` defined, the default becomes 5_000, which is 100 µs.

Ports:
- `FPGA_CLK1_50`  input  1  system clock, 50 MHz; the only clock.
- `KEY`  input  2  push-buttons, active-low, asynchronous.
  - KEY[0] is the reset: asynchronous, active-low.
  - KEY[1] is a user button.
- `SW`  input  4  slide switches, asynchronous to the clock.
- `LED`  output  8  user LEDs, active-high.
- `hws_ifm`  interface  `hws_if`  hardware-support bundle.
  - `hws_if` is a SystemVerilog interface with no ports, instantiable as `hws_if hws_ifm();`.
  - This block neither reads nor drives any of its members.

## Operation
- **Reset synchronizer**
  - Internal `rst_n` is asserted immediately (asynchronously) when KEY[0]=0.
  - Release is synchronous: a 2-flop chain clocked by FPGA_CLK1_50, fed with constant 1 and cleared asynchronously by KEY[0].
  - Every other flop in the block uses `rst_n` as an asynchronous active-low clear.
- **Heartbeat, LED[0]**
  - Counter `cnt` has width $clog2(HALF_PERIOD) and counts 0 … HALF_PERIOD-1.
  - When cnt = HALF_PERIOD-1: cnt returns to 0 and LED[0] toggles.
  - Result: square wave of period 2·HALF_PERIOD cycles.
- **Phase counter, LED[3:2]**
  - 2-bit counter, incremented on every 0→1 transition of LED[0].
  - Wraps from 3 to 0.
- **Button indicator, LED[1]**
  - LED[1] = NOT KEY[1], passed through a 2-flop synchronizer.
  - Lit while KEY[1] is pressed.
- **Switch mirror, LED[7:4]**
  - LED[7:4] = SW[3:0], passed through a 2-flop synchronizer.
- No other state exists. `hws_ifm` is unconnected internally.

## Timing
- **Reset values.** While `rst_n`=0:
  - LED = 8'h00, cnt = 0.
  - Phase counter = 0.
  - Synchronizer flops = 0.
- **Reset assertion.**
  - KEY[0] falling forces LED to 0 within combinational/clear delay, with no clock needed.
  - Reset mid-count discards all progress.
- **Reset release.**
  - `rst_n` rises on the 2nd rising clock edge after KEY[0] returns high.
  - cnt starts incrementing on the following edge.
- **First LED[0] toggle (0→1)** occurs HALF_PERIOD cycles after `rst_n` rises.
- **Phase counter.** LED[3:2] updates on the same edge that LED[0] goes 0→1.
  - It therefore reads 1 during the first high phase.
  - It reads 0 again after 4 full heartbeat periods.
- **LED[1] and LED[7:4] latency.** A change on KEY[1] or SW appears on the LED 2 rising edges after it is sampled.
- **Glitches.**
  - LED outputs are all driven directly from flops and are glitch-free.
  - Exception: reset-driven clears.
- **Simultaneous events.** Switch/button changes during counter wrap are independent; no interaction.

## Test plan
- **Reset pulse.** Clock 20 ns period, KEY[0]=1, then KEY[0]=0 at 128 ns, then KEY[0]=1 at 256 ns.
  - LED = 8'h00 from 128 ns.
  - `rst_n` rises on the 2nd edge after 256 ns.
- **Heartbeat (SIMULATION, HALF_PERIOD=5000).**
  - LED[0] rises 100 µs after reset release, then toggles every 100 µs.
  - Over a 4 ms run this gives about 39–40 toggles.
  - Period measured edge-to-edge = 200 µs ± 0 cycles.
- **Phase counter.**
  - LED[3:2] reads 1, 2, 3, 0, 1 on successive LED[0] rising edges.
  - Stable between those edges.
- **Switch mirror.**
  - SW=4'b1010 → LED[7:4]=4'b1010 after exactly 2 clock edges.
  - SW=4'b0101 → LED[7:4]=4'b0101 after exactly 2 clock edges.
  - While KEY[0]=0, LED[7:4]=0.
- **Button indicator.**
  - KEY[1]=0 → LED[1]=1 after 2 edges.
  - KEY[1]=1 → LED[1]=0 after 2 edges.
- **Reset mid-operation.** Assert KEY[0]=0 for 3 cycles while LED[0]=1 and LED[3:2]=2.
  - All LEDs clear immediately.
  - After release, the heartbeat restarts from cnt=0: first rise after HALF_PERIOD cycles, LED[3:2]=1.

Source files
------------

// File: rtl/hws_if.sv
// hws_if -- hardware-support bundle carried through the board top.
//   master : drives req/addr/wdata (the surrounding SoC side)
//   slave  : observes req/addr/wdata (fpga_top exposes this side; it does
//            not currently use any member)
interface hws_if;
  logic        req;
  logic [7:0]  addr;
  logic [31:0] wdata;

  modport master (output req, addr, wdata);
  modport slave  (input  req, addr, wdata);
endinterface

// File: rtl/fpga_top.sv
// fpga_top -- board-level top of the SoC-FPGA video controller.
//   FPGA_CLK1_50 : 50 MHz board clock, the only clock
//   KEY[0]       : active-low reset button (async assert, sync release)
//   KEY[1]       : user button, active-low, asynchronous
//   SW[3:0]      : slide switches, asynchronous
//   LED[0]       : heartbeat, period 2*HALF_PERIOD cycles
//   LED[1]       : lit while KEY[1] is pressed (2-flop synchronized)
//   LED[3:2]     : heartbeat phase, +1 on every LED[0] rising edge
//   LED[7:4]     : SW[3:0] through a 2-flop synchronizer
//   hws_ifm      : hardware-support bundle, passed through untouched

// One synchronizer lane: two flops, cleared with the block reset.
module fpga_top_sync2 (
  input  logic gclk,
  input  logic grst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

module fpga_top #(
`ifdef SIMULATION
  parameter int HALF_PERIOD = 5_000
`else
  parameter int HALF_PERIOD = 25_000_000
`endif
) (
  input  logic       FPGA_CLK1_50,
  input  logic [1:0] KEY,
  input  logic [3:0] SW,
  output logic [7:0] LED,
  hws_if.slave       hws_ifm
);
  // Guard keeps the counter at least one bit wide for HALF_PERIOD=1.
  localparam int CW        = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int NUM_LANES = 5;  // KEY[1] + SW[3:0]

  // Reset: KEY[0] clears the chain immediately; the constant 1 walks
  // through two flops so rst_n rises on the 2nd edge after release.
  logic rst_meta, rst_n;

  always_ff @(posedge FPGA_CLK1_50 or negedge KEY[0]) begin
    if (!KEY[0]) begin
      rst_meta <= 1'b0;
      rst_n    <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n    <= rst_meta;
    end
  end

  // Asynchronous inputs, lane 0 is the (inverted) button, 4:1 the switches.
  logic [NUM_LANES-1:0] sync_d, sync_q;

  assign sync_d = {SW, ~KEY[1]};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_sync
    fpga_top_sync2 u_sync (
      .gclk   (FPGA_CLK1_50),
      .grst_n (rst_n),
      .d      (sync_d[g]),
      .q      (sync_q[g])
    );
  end

  // Heartbeat and phase counter.
  logic [CW-1:0] cnt;
  logic          hb;
  logic [1:0]    phase;
  logic          wrap;

  assign wrap = (cnt == CW'(HALF_PERIOD - 1));

  always_ff @(posedge FPGA_CLK1_50 or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      hb    <= 1'b0;
      phase <= 2'd0;
    end else if (wrap) begin
      cnt <= '0;
      hb  <= ~hb;
      // Phase steps on the same edge that takes LED[0] low->high.
      if (!hb) phase <= phase + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Every LED bit comes straight from a flop.
  assign LED = {sync_q[4:1], phase, sync_q[0], hb};

endmodule

// File: tb/tb_fpga_top.sv
module tb_fpga_top;
  localparam int HP = 10;

  logic       clk = 1'b0;
  logic [1:0] key;
  logic [3:0] sw;
  logic [7:0] led;
  int         pass_cnt = 0;
  int         total    = 0;

  hws_if hws_ifm();

  fpga_top #(.HALF_PERIOD(HP)) dut (
    .FPGA_CLK1_50 (clk),
    .KEY          (key),
    .SW           (sw),
    .LED          (led),
    .hws_ifm      (hws_ifm)
  );

  always #10 clk = ~clk;

  // Advance one rising edge, then step off it before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    key = 2'b01; sw = 4'hF;            // button pressed, switches on
    #128;
    key = 2'b00;
    #1;
    total++;
    if (led !== 8'h00) $display("FAIL reset_assert led=%h exp=00", led);
    else pass_cnt++;
    #126;                               // t=255
    total++;
    if (led !== 8'h00) $display("FAIL reset_hold led=%h exp=00", led);
    else pass_cnt++;
    #1;                                 // t=256
    key = 2'b11; sw = 4'h0;
    tick();                             // edge 270: rst_meta only
    total++;
    if (led !== 8'h00) $display("FAIL reset_edge1 led=%h exp=00", led);
    else pass_cnt++;
    tick();                             // edge 290: rst_n rises
    total++;
    if (led !== 8'h00) $display("FAIL reset_edge2 led=%h exp=00", led);
    else pass_cnt++;
  endtask

  // Entered right after the edge on which rst_n rose.
  task automatic test_heartbeat();
    int n;
    repeat (HP - 1) tick();
    total++;
    if (led[0] !== 1'b0) $display("FAIL hb_before_rise led0=%b exp=0", led[0]);
    else pass_cnt++;
    tick();
    total++;
    if (led[0] !== 1'b1) $display("FAIL hb_first_rise led0=%b exp=1", led[0]);
    else pass_cnt++;
    total++;
    if (led[3:2] !== 2'd1) $display("FAIL phase_first got=%0d exp=1", led[3:2]);
    else pass_cnt++;
    n = 0;
    do begin tick(); n++; end while (led[0] === 1'b1 && n < 100);
    total++;
    if (n !== HP) $display("FAIL hb_high_len got=%0d exp=%0d", n, HP);
    else pass_cnt++;
    n = 0;
    do begin tick(); n++; end while (led[0] === 1'b0 && n < 100);
    total++;
    if (n !== HP) $display("FAIL hb_low_len got=%0d exp=%0d", n, HP);
    else pass_cnt++;
    total++;
    if (led[3:2] !== 2'd2) $display("FAIL phase_second got=%0d exp=2", led[3:2]);
    else pass_cnt++;
  endtask

  // Entered on an LED[0] rising edge with phase 2.
  task automatic test_phase();
    logic [1:0] exp_ph [3] = '{2'd3, 2'd0, 2'd1};
    for (int k = 0; k < 3; k++) begin
      int         n;
      logic       prev0;
      logic [1:0] held;
      bit         stable;
      n = 0; stable = 1'b1; held = led[3:2];
      forever begin
        prev0 = led[0];
        tick(); n++;
        if (led[0] === 1'b1 && prev0 === 1'b0) break;
        if (led[3:2] !== held) stable = 1'b0;
        if (n >= 100) break;
      end
      total++;
      if (n !== 2 * HP) $display("FAIL phase_period%0d got=%0d exp=%0d", k, n, 2 * HP);
      else pass_cnt++;
      total++;
      if (led[3:2] !== exp_ph[k]) $display("FAIL phase_step%0d got=%0d exp=%0d", k, led[3:2], exp_ph[k]);
      else pass_cnt++;
      total++;
      if (!stable) $display("FAIL phase_stable%0d changed between rises", k);
      else pass_cnt++;
    end
  endtask

  task automatic test_switch();
    logic [3:0] pat [2] = '{4'b1010, 4'b0101};
    logic [3:0] prev;
    prev = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      sw = pat[k];
      tick();
      total++;
      if (led[7:4] !== prev) $display("FAIL sw_edge1_%0d got=%b exp=%b", k, led[7:4], prev);
      else pass_cnt++;
      tick();
      total++;
      if (led[7:4] !== pat[k]) $display("FAIL sw_edge2_%0d got=%b exp=%b", k, led[7:4], pat[k]);
      else pass_cnt++;
      prev = pat[k];
    end
  endtask

  task automatic test_button();
    key[1] = 1'b0;
    tick();
    total++;
    if (led[1] !== 1'b0) $display("FAIL btn_press_edge1 got=%b exp=0", led[1]);
    else pass_cnt++;
    tick();
    total++;
    if (led[1] !== 1'b1) $display("FAIL btn_press_edge2 got=%b exp=1", led[1]);
    else pass_cnt++;
    key[1] = 1'b1;
    tick();
    total++;
    if (led[1] !== 1'b1) $display("FAIL btn_release_edge1 got=%b exp=1", led[1]);
    else pass_cnt++;
    tick();
    total++;
    if (led[1] !== 1'b0) $display("FAIL btn_release_edge2 got=%b exp=0", led[1]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    while (!(led[0] === 1'b1 && led[3:2] === 2'd2) && n < 200) begin tick(); n++; end
    total++;
    if (n >= 200) $display("FAIL mid_find led=%h exp=led0=1 phase=2", led);
    else pass_cnt++;
    key[0] = 1'b0;
    #1;
    total++;
    if (led !== 8'h00) $display("FAIL mid_assert led=%h exp=00", led);
    else pass_cnt++;
    repeat (3) tick();
    total++;
    if (led !== 8'h00) $display("FAIL mid_hold led=%h exp=00", led);
    else pass_cnt++;
    key[0] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (led[0] === 1'b0 && n < 100);
    // 2 edges to release rst_n, then HP edges to the first rise
    total++;
    if (n !== HP + 2) $display("FAIL mid_first_rise got=%0d exp=%0d", n, HP + 2);
    else pass_cnt++;
    total++;
    if (led[3:2] !== 2'd1) $display("FAIL mid_phase got=%0d exp=1", led[3:2]);
    else pass_cnt++;
    total++;
    if (led[7:4] !== 4'b0101) $display("FAIL mid_sw got=%b exp=0101", led[7:4]);
    else pass_cnt++;
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    hws_ifm.req   = 1'b0;
    hws_ifm.addr  = 8'h00;
    hws_ifm.wdata = 32'h0;
    test_reset();
    test_heartbeat();
    test_phase();
    test_switch();
    test_button();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
